// File: rtl/riscv_imem_ctrl.sv
// rtl/riscv_imem_ctrl.sv - instruction fetch bus interface with in-order response tracking
// Define RISCV_IMEM_CTRL_RVC_EN to allow halfword-aligned (compressed) fetch addresses.
module riscv_imem_ctrl #(
  parameter int XLEN            = 32,
  parameter int PARCEL_SIZE     = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [XLEN-1:0]        if_nxt_pc,
  input  logic                   if_stall,
  input  logic                   if_flush,
  output logic                   if_stall_nxt_pc,
  output logic [PARCEL_SIZE-1:0] if_parcel,
  output logic [XLEN-1:0]        if_parcel_pc,
  output logic [1:0]             if_parcel_valid,
  output logic                   if_parcel_misaligned,
  output logic                   if_parcel_page_fault,
  output logic                   mem_req,
  output logic [XLEN-1:0]        mem_adr,
  input  logic                   mem_ack,
  input  logic                   mem_rvalid,
  input  logic [PARCEL_SIZE-1:0] mem_rdata,
  input  logic                   mem_err
);

  localparam int D  = MAX_OUTSTANDING;
  localparam int PW = (D > 1) ? $clog2(D) : 1;
  localparam int CW = $clog2(D + 1);
  localparam int OW = CW + 2;

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  function automatic ptr_t ptr_add(input ptr_t p, input int off);
    return ptr_t'((int'(p) + off) % D);
  endfunction

  // Pending entries: accepted fetches awaiting retirement, oldest at pend_rd_q
  logic [XLEN-1:0]        pend_pc_q    [D];
  logic [XLEN-1:0]        pend_pc_d    [D];
  logic                   pend_local_q [D];
  logic                   pend_local_d [D];
  logic                   pend_done_q  [D];
  logic                   pend_done_d  [D];
  logic [PARCEL_SIZE-1:0] pend_data_q  [D];
  logic [PARCEL_SIZE-1:0] pend_data_d  [D];
  logic                   pend_err_q   [D];
  logic                   pend_err_d   [D];
  ptr_t                   pend_rd_q, pend_rd_d, pend_wr_q, pend_wr_d;
  cnt_t                   pend_cnt_q, pend_cnt_d;

  logic [PARCEL_SIZE-1:0] resp_data_q  [D];
  logic [PARCEL_SIZE-1:0] resp_data_d  [D];
  logic [XLEN-1:0]        resp_pc_q    [D];
  logic [XLEN-1:0]        resp_pc_d    [D];
  logic                   resp_err_q   [D];
  logic                   resp_err_d   [D];
  logic                   resp_mis_q   [D];
  logic                   resp_mis_d   [D];
  ptr_t                   resp_rd_q, resp_rd_d, resp_wr_q, resp_wr_d;
  cnt_t                   resp_cnt_q, resp_cnt_d;

  cnt_t                   disc_cnt_q, disc_cnt_d;

  logic [PARCEL_SIZE-1:0] parcel_q, parcel_d;
  logic [XLEN-1:0]        parcel_pc_q, parcel_pc_d;
  logic [1:0]             parcel_valid_q, parcel_valid_d;
  logic                   parcel_mis_q, parcel_mis_d;
  logic                   parcel_fault_q, parcel_fault_d;

  logic                   misaligned;
  logic [OW-1:0]          occ;
  logic                   capacity;
  logic                   acc_mis;
  logic                   accept;

  logic                   tgt_found;
  logic                   tgt_head;
  ptr_t                   tgt_idx;
  cnt_t                   bus_out;

  logic                   rv_disc;
  logic                   rv_hit;
  logic                   ret;
  logic [PARCEL_SIZE-1:0] ret_data;
  logic [XLEN-1:0]        ret_pc;
  logic                   ret_err;
  logic                   ret_mis;
  logic                   go;
  logic                   push;
  logic                   pop;
  logic                   dlv;
  logic [PARCEL_SIZE-1:0] dlv_data;
  logic [XLEN-1:0]        dlv_pc;
  logic                   dlv_err;
  logic                   dlv_mis;

`ifdef RISCV_IMEM_CTRL_RVC_EN
  assign misaligned = if_nxt_pc[0];
`else
  assign misaligned = |if_nxt_pc[1:0];
`endif

  assign occ      = OW'(pend_cnt_q) + OW'(resp_cnt_q) + OW'(disc_cnt_q);
  assign capacity = occ < OW'(D);
  assign mem_req  = !rst && !if_stall && !if_flush && capacity && !misaligned;
  assign acc_mis  = !rst && !if_stall && !if_flush && capacity && misaligned;
  assign accept   = (mem_req && mem_ack) || acc_mis;
  assign mem_adr  = {if_nxt_pc[XLEN-1:2], 2'b00};

  assign if_stall_nxt_pc      = !accept;
  assign if_parcel            = parcel_q;
  assign if_parcel_pc         = parcel_pc_q;
  assign if_parcel_valid      = parcel_valid_q;
  assign if_parcel_misaligned = parcel_mis_q;
  assign if_parcel_page_fault = parcel_fault_q;

  // The next bus response belongs to the oldest bus entry still waiting for data
  always_comb begin
    tgt_found = 1'b0;
    tgt_head  = 1'b0;
    tgt_idx   = pend_rd_q;
    bus_out   = '0;
    for (int i = 0; i < D; i++) begin
      if (i < int'(pend_cnt_q)) begin
        if (!pend_local_q[ptr_add(pend_rd_q, i)] && !pend_done_q[ptr_add(pend_rd_q, i)]) begin
          bus_out = bus_out + cnt_t'(1);
          if (!tgt_found) begin
            tgt_found = 1'b1;
            tgt_head  = (i == 0);
            tgt_idx   = ptr_add(pend_rd_q, i);
          end
        end
      end
    end
  end

  always_comb begin
    rv_disc  = mem_rvalid && (disc_cnt_q != '0);
    rv_hit   = mem_rvalid && (disc_cnt_q == '0) && tgt_found;

    ret      = 1'b0;
    ret_data = '0;
    ret_err  = 1'b0;
    ret_mis  = 1'b0;
    ret_pc   = pend_pc_q[pend_rd_q];
    if (pend_cnt_q != '0) begin
      if (pend_local_q[pend_rd_q]) begin
        ret     = 1'b1;
        ret_mis = 1'b1;
      end else if (pend_done_q[pend_rd_q]) begin
        ret      = 1'b1;
        ret_data = pend_data_q[pend_rd_q];
        ret_err  = pend_err_q[pend_rd_q];
      end else if (rv_hit) begin
        ret      = 1'b1;
        ret_data = mem_rdata;
        ret_err  = mem_err;
      end
    end

    pend_pc_d    = pend_pc_q;
    pend_local_d = pend_local_q;
    pend_done_d  = pend_done_q;
    pend_data_d  = pend_data_q;
    pend_err_d   = pend_err_q;
    pend_rd_d    = pend_rd_q;
    pend_wr_d    = pend_wr_q;
    pend_cnt_d   = pend_cnt_q + cnt_t'(accept) - cnt_t'(ret);

    // Data for a non-head bus entry is parked until that entry reaches the head
    if (rv_hit && !tgt_head) begin
      pend_done_d[tgt_idx] = 1'b1;
      pend_data_d[tgt_idx] = mem_rdata;
      pend_err_d[tgt_idx]  = mem_err;
    end
    if (ret) begin
      pend_rd_d = ptr_add(pend_rd_q, 1);
    end
    if (accept) begin
      pend_pc_d[pend_wr_q]    = if_nxt_pc;
      pend_local_d[pend_wr_q] = acc_mis;
      pend_done_d[pend_wr_q]  = 1'b0;
      pend_wr_d               = ptr_add(pend_wr_q, 1);
    end

    go       = !if_stall && !if_flush;
    pop      = 1'b0;
    push     = 1'b0;
    dlv      = 1'b0;
    dlv_data = resp_data_q[resp_rd_q];
    dlv_pc   = resp_pc_q[resp_rd_q];
    dlv_err  = resp_err_q[resp_rd_q];
    dlv_mis  = resp_mis_q[resp_rd_q];
    if (go && (resp_cnt_q != '0)) begin
      pop  = 1'b1;
      dlv  = 1'b1;
      push = ret;
    end else if (go && ret) begin
      dlv      = 1'b1;
      dlv_data = ret_data;
      dlv_pc   = ret_pc;
      dlv_err  = ret_err;
      dlv_mis  = ret_mis;
    end else begin
      push = ret;
    end

    resp_data_d = resp_data_q;
    resp_pc_d   = resp_pc_q;
    resp_err_d  = resp_err_q;
    resp_mis_d  = resp_mis_q;
    resp_rd_d   = pop ? ptr_add(resp_rd_q, 1) : resp_rd_q;
    resp_wr_d   = resp_wr_q;
    resp_cnt_d  = resp_cnt_q + cnt_t'(push) - cnt_t'(pop);
    if (push) begin
      resp_data_d[resp_wr_q] = ret_data;
      resp_pc_d[resp_wr_q]   = ret_pc;
      resp_err_d[resp_wr_q]  = ret_err;
      resp_mis_d[resp_wr_q]  = ret_mis;
      resp_wr_d              = ptr_add(resp_wr_q, 1);
    end

    parcel_d       = parcel_q;
    parcel_pc_d    = parcel_pc_q;
    parcel_mis_d   = parcel_mis_q;
    parcel_fault_d = parcel_fault_q;
    parcel_valid_d = 2'b00;
    if (dlv) begin
      parcel_d       = dlv_data;
      parcel_pc_d    = dlv_pc;
      parcel_mis_d   = dlv_mis;
      parcel_fault_d = dlv_err;
`ifdef RISCV_IMEM_CTRL_RVC_EN
      parcel_valid_d = dlv_pc[1] ? 2'b10 : 2'b11;
`else
      parcel_valid_d = 2'b11;
`endif
    end

    disc_cnt_d = disc_cnt_q - cnt_t'(rv_disc);
    // Every bus read still owed to a flushed entry must be swallowed later
    if (if_flush) begin
      pend_rd_d  = '0;
      pend_wr_d  = '0;
      pend_cnt_d = '0;
      resp_rd_d  = '0;
      resp_wr_d  = '0;
      resp_cnt_d = '0;
      disc_cnt_d = disc_cnt_q + bus_out - cnt_t'(rv_disc || rv_hit);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < D; i++) begin
        pend_pc_q[i]    <= '0;
        pend_local_q[i] <= 1'b0;
        pend_done_q[i]  <= 1'b0;
        pend_data_q[i]  <= '0;
        pend_err_q[i]   <= 1'b0;
        resp_data_q[i]  <= '0;
        resp_pc_q[i]    <= '0;
        resp_err_q[i]   <= 1'b0;
        resp_mis_q[i]   <= 1'b0;
      end
      pend_rd_q      <= '0;
      pend_wr_q      <= '0;
      pend_cnt_q     <= '0;
      resp_rd_q      <= '0;
      resp_wr_q      <= '0;
      resp_cnt_q     <= '0;
      disc_cnt_q     <= '0;
      parcel_q       <= '0;
      parcel_pc_q    <= '0;
      parcel_valid_q <= 2'b00;
      parcel_mis_q   <= 1'b0;
      parcel_fault_q <= 1'b0;
    end else begin
      pend_pc_q      <= pend_pc_d;
      pend_local_q   <= pend_local_d;
      pend_done_q    <= pend_done_d;
      pend_data_q    <= pend_data_d;
      pend_err_q     <= pend_err_d;
      resp_data_q    <= resp_data_d;
      resp_pc_q      <= resp_pc_d;
      resp_err_q     <= resp_err_d;
      resp_mis_q     <= resp_mis_d;
      pend_rd_q      <= pend_rd_d;
      pend_wr_q      <= pend_wr_d;
      pend_cnt_q     <= pend_cnt_d;
      resp_rd_q      <= resp_rd_d;
      resp_wr_q      <= resp_wr_d;
      resp_cnt_q     <= resp_cnt_d;
      disc_cnt_q     <= disc_cnt_d;
      parcel_q       <= parcel_d;
      parcel_pc_q    <= parcel_pc_d;
      parcel_valid_q <= parcel_valid_d;
      parcel_mis_q   <= parcel_mis_d;
      parcel_fault_q <= parcel_fault_d;
    end
  end

endmodule

// File: tb/tb_riscv_imem_ctrl.sv
// tb/tb_riscv_imem_ctrl.sv - directed vector bench for riscv_imem_ctrl
// Default build (compressed fetch disabled), MAX_OUTSTANDING=2.
module tb_riscv_imem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_nxt_pc;
  logic        if_stall;
  logic        if_flush;
  logic        if_stall_nxt_pc;
  logic [31:0] if_parcel;
  logic [31:0] if_parcel_pc;
  logic [1:0]  if_parcel_valid;
  logic        if_parcel_misaligned;
  logic        if_parcel_page_fault;
  logic        mem_req;
  logic [31:0] mem_adr;
  logic        mem_ack;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        mem_err;

  int total = 0;
  int bad   = 0;

  riscv_imem_ctrl #(.XLEN(32), .PARCEL_SIZE(32), .MAX_OUTSTANDING(2)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .if_nxt_pc            (if_nxt_pc),
    .if_stall             (if_stall),
    .if_flush             (if_flush),
    .if_stall_nxt_pc      (if_stall_nxt_pc),
    .if_parcel            (if_parcel),
    .if_parcel_pc         (if_parcel_pc),
    .if_parcel_valid      (if_parcel_valid),
    .if_parcel_misaligned (if_parcel_misaligned),
    .if_parcel_page_fault (if_parcel_page_fault),
    .mem_req              (mem_req),
    .mem_adr              (mem_adr),
    .mem_ack              (mem_ack),
    .mem_rvalid           (mem_rvalid),
    .mem_rdata            (mem_rdata),
    .mem_err              (mem_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        stall;
    logic        ack;
    logic        rv;
    logic [31:0] rdata;
    logic        err;
    logic        e_snp;
    logic        e_req;
    logic [1:0]  e_vld;
    logic [31:0] e_par;
    logic [31:0] e_ppc;
    logic        e_mis;
    logic        e_pf;
  } vec_t;

  vec_t tbl[14];

  function automatic vec_t mk(input logic [31:0] pc, input logic stall, input logic ack,
                              input logic rv, input logic [31:0] rdata, input logic err,
                              input logic e_snp, input logic e_req, input logic [1:0] e_vld,
                              input logic [31:0] e_par, input logic [31:0] e_ppc,
                              input logic e_mis, input logic e_pf);
    vec_t v;
    v.pc = pc; v.stall = stall; v.ack = ack; v.rv = rv; v.rdata = rdata; v.err = err;
    v.e_snp = e_snp; v.e_req = e_req; v.e_vld = e_vld; v.e_par = e_par;
    v.e_ppc = e_ppc; v.e_mis = e_mis; v.e_pf = e_pf;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs on the falling edge; checks follow 1ns later
  task automatic drive(input logic [31:0] pc, input logic stall, input logic flush,
                       input logic ack, input logic rv, input logic [31:0] rdata,
                       input logic err);
    @(negedge clk);
    if_nxt_pc  = pc;
    if_stall   = stall;
    if_flush   = flush;
    mem_ack    = ack;
    mem_rvalid = rv;
    mem_rdata  = rdata;
    mem_err    = err;
    #1;
  endtask

  task automatic chk_parcel(input string name, input logic [31:0] par, input logic [31:0] ppc);
    chk({name, "_vld"}, 32'(if_parcel_valid), 32'h3);
    chk({name, "_par"}, if_parcel, par);
    chk({name, "_pc"}, if_parcel_pc, ppc);
  endtask

  initial begin
    rst        = 1'b1;
    if_nxt_pc  = '0;
    if_stall   = 1'b0;
    if_flush   = 1'b0;
    mem_ack    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    mem_err    = 1'b0;

    //          pc        stl ack rv rdata         err  snp req vld    par           ppc       mis pf
    tbl[0]  = mk(32'h200, 0, 1, 0, 32'h0,         0,   0,  1,  2'b00, 32'h0,        32'h0,    0,  0);
    tbl[1]  = mk(32'h204, 0, 0, 1, 32'h00000013,  0,   1,  1,  2'b00, 32'h0,        32'h0,    0,  0);
    tbl[2]  = mk(32'h204, 0, 0, 0, 32'h0,         0,   1,  1,  2'b11, 32'h00000013, 32'h200,  0,  0);
    tbl[3]  = mk(32'h208, 0, 1, 0, 32'h0,         0,   0,  1,  2'b00, 32'h0,        32'h0,    0,  0);
    tbl[4]  = mk(32'h20C, 0, 1, 0, 32'h0,         0,   0,  1,  2'b00, 32'h0,        32'h0,    0,  0);
    tbl[5]  = mk(32'h210, 0, 1, 0, 32'h0,         0,   1,  0,  2'b00, 32'h0,        32'h0,    0,  0);
    tbl[6]  = mk(32'h210, 0, 1, 1, 32'hAAAA0001,  1,   1,  0,  2'b00, 32'h0,        32'h0,    0,  0);
    tbl[7]  = mk(32'h210, 0, 1, 0, 32'h0,         0,   0,  1,  2'b11, 32'hAAAA0001, 32'h208,  0,  1);
    tbl[8]  = mk(32'h20A, 0, 1, 1, 32'hBBBB0002,  0,   1,  0,  2'b00, 32'h0,        32'h0,    0,  0);
    tbl[9]  = mk(32'h20A, 0, 1, 0, 32'h0,         0,   0,  0,  2'b11, 32'hBBBB0002, 32'h20C,  0,  0);
    tbl[10] = mk(32'h300, 0, 1, 1, 32'hCCCC0003,  0,   1,  0,  2'b00, 32'h0,        32'h0,    0,  0);
    tbl[11] = mk(32'h300, 0, 0, 0, 32'h0,         0,   1,  1,  2'b11, 32'hCCCC0003, 32'h210,  0,  0);
    tbl[12] = mk(32'h300, 0, 0, 0, 32'h0,         0,   1,  1,  2'b11, 32'h0,        32'h20A,  1,  0);
    tbl[13] = mk(32'h300, 0, 0, 0, 32'h0,         0,   1,  1,  2'b00, 32'h0,        32'h0,    0,  0);

    repeat (2) @(negedge clk);
    #1;
    chk("rst_vld", 32'(if_parcel_valid), 32'h0);
    chk("rst_par", if_parcel, 32'h0);
    chk("rst_ppc", if_parcel_pc, 32'h0);
    chk("rst_flags", {30'h0, if_parcel_misaligned, if_parcel_page_fault}, 32'h0);
    chk("rst_req", 32'(mem_req), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < 14; k++) begin
      drive(tbl[k].pc, tbl[k].stall, 1'b0, tbl[k].ack, tbl[k].rv, tbl[k].rdata, tbl[k].err);
      chk($sformatf("v%0d_snp", k), 32'(if_stall_nxt_pc), 32'(tbl[k].e_snp));
      chk($sformatf("v%0d_req", k), 32'(mem_req), 32'(tbl[k].e_req));
      chk($sformatf("v%0d_adr", k), mem_adr, tbl[k].pc & 32'hFFFF_FFFC);
      chk($sformatf("v%0d_vld", k), 32'(if_parcel_valid), 32'(tbl[k].e_vld));
      if (tbl[k].e_vld != 2'b00) begin
        chk($sformatf("v%0d_par", k), if_parcel, tbl[k].e_par);
        chk($sformatf("v%0d_ppc", k), if_parcel_pc, tbl[k].e_ppc);
        chk($sformatf("v%0d_mis", k), 32'(if_parcel_misaligned), 32'(tbl[k].e_mis));
        chk($sformatf("v%0d_pf", k), 32'(if_parcel_page_fault), 32'(tbl[k].e_pf));
      end
    end

    // Stall buffering: two responses arrive while stalled, then drain back to back
    drive(32'h500, 0, 0, 1, 0, 32'h0, 0);
    chk("st_acc0", 32'(if_stall_nxt_pc), 32'h0);
    drive(32'h504, 0, 0, 1, 0, 32'h0, 0);
    chk("st_acc1", 32'(if_stall_nxt_pc), 32'h0);
    drive(32'h600, 1, 0, 1, 1, 32'h11111111, 0);
    chk("st_req", 32'(mem_req), 32'h0);
    chk("st_vld0", 32'(if_parcel_valid), 32'h0);
    drive(32'h600, 1, 0, 1, 1, 32'h22222222, 0);
    chk("st_vld1", 32'(if_parcel_valid), 32'h0);
    drive(32'h600, 1, 0, 1, 0, 32'h0, 0);
    chk("st_vld2", 32'(if_parcel_valid), 32'h0);
    drive(32'h600, 0, 0, 0, 0, 32'h0, 0);
    chk("st_vld3", 32'(if_parcel_valid), 32'h0);
    chk("st_full", 32'(mem_req), 32'h0);
    drive(32'h600, 0, 0, 0, 0, 32'h0, 0);
    chk_parcel("st_p0", 32'h11111111, 32'h500);
    drive(32'h600, 0, 0, 0, 0, 32'h0, 0);
    chk_parcel("st_p1", 32'h22222222, 32'h504);
    drive(32'h600, 0, 0, 0, 0, 32'h0, 0);
    chk("st_end", 32'(if_parcel_valid), 32'h0);

    // Flush with two reads in flight: their data is swallowed, new stream survives
    drive(32'h700, 0, 0, 1, 0, 32'h0, 0);
    drive(32'h704, 0, 0, 1, 0, 32'h0, 0);
    drive(32'h708, 0, 1, 1, 0, 32'h0, 0);
    chk("fl_req", 32'(mem_req), 32'h0);
    chk("fl_snp", 32'(if_stall_nxt_pc), 32'h1);
    drive(32'h400, 0, 0, 1, 1, 32'hD0D0D0D0, 0);
    chk("fl_full", 32'(mem_req), 32'h0);
    chk("fl_vld0", 32'(if_parcel_valid), 32'h0);
    drive(32'h400, 0, 0, 1, 1, 32'hD1D1D1D1, 0);
    chk("fl_acc", 32'(if_stall_nxt_pc), 32'h0);
    chk("fl_vld1", 32'(if_parcel_valid), 32'h0);
    drive(32'h800, 0, 0, 0, 1, 32'hD2D2D2D2, 0);
    chk("fl_vld2", 32'(if_parcel_valid), 32'h0);
    drive(32'h800, 0, 0, 0, 0, 32'h0, 0);
    chk_parcel("fl_d2", 32'hD2D2D2D2, 32'h400);
    drive(32'h800, 0, 0, 0, 0, 32'h0, 0);
    chk("fl_end", 32'(if_parcel_valid), 32'h0);

    // Reset while a read is pending, a parcel is on the outputs
    drive(32'h900, 0, 0, 1, 0, 32'h0, 0);
    drive(32'h904, 0, 0, 1, 0, 32'h0, 0);
    drive(32'h904, 1, 0, 0, 1, 32'hEEEE0000, 0);
    drive(32'hA00, 0, 0, 0, 0, 32'h0, 0);
    drive(32'hA00, 0, 0, 0, 0, 32'h0, 0);
    chk_parcel("rs_pre", 32'hEEEE0000, 32'h900);
    #1 rst = 1'b1;
    #1;
    chk("rs_vld", 32'(if_parcel_valid), 32'h0);
    chk("rs_par", if_parcel, 32'h0);
    chk("rs_ppc", if_parcel_pc, 32'h0);
    chk("rs_req", 32'(mem_req), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(32'hA00, 0, 0, 0, 1, 32'hBAD0BAD0, 0);
    chk("rs_late0", 32'(if_parcel_valid), 32'h0);
    drive(32'hA00, 0, 0, 1, 0, 32'h0, 0);
    chk("rs_late1", 32'(if_parcel_valid), 32'h0);
    chk("rs_acc", 32'(if_stall_nxt_pc), 32'h0);
    drive(32'hA04, 0, 0, 0, 1, 32'h0F0F0F0F, 0);
    chk("rs_vld2", 32'(if_parcel_valid), 32'h0);
    drive(32'hA04, 0, 0, 0, 0, 32'h0, 0);
    chk_parcel("rs_new", 32'h0F0F0F0F, 32'hA00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
